// File: rtl/arm_run_controller.sv
// Run/halt/single-step sequencer for the ARM core: holds core reset, gates the
// pipeline clock-enable and counts executed cycles. Optional macro: BREAKPOINT_EN.
module arm_run_controller #(
  parameter int RST_HOLD     = 16,
  parameter bit START_HALTED = 1'b0,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             halt_i,
  input  logic             step_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      bp_addr_i,
  input  logic             bp_valid_i,
  output logic             core_rst,
  output logic             core_en,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_STEP  = 2'd3
  } state_t;

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_t            state;
  state_t            state_n;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              run_q;
  logic              halt_q;
  logic              step_q;
  logic              run_req;
  logic              halt_req;
  logic              step_req;
  logic              hit;

  // Keys are registered once; a level that is already high when reset lifts
  // produces a request only while still in RESET, where it is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q  <= 1'b0;
      halt_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      run_q  <= run_i;
      halt_q <= halt_i;
      step_q <= step_i;
    end
  end

  assign run_req  = run_i  & ~run_q;
  assign halt_req = halt_i & ~halt_q;
  assign step_req = step_i & ~step_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (state == S_RESET && !hold_done) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  assign hold_done = (hold_cnt == HOLD_W'(RST_HOLD - 1));

`ifdef BREAKPOINT_EN
  logic skip;

  // skip lets the core leave a breakpoint PC without immediately re-hitting it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skip <= 1'b0;
    end else if (state == S_HALT && state_n == S_RUN) begin
      skip <= 1'b1;
    end else if (state == S_RUN) begin
      skip <= 1'b0;
    end
  end

  assign hit = (state == S_RUN) & bp_valid_i & (pc_i == bp_addr_i) & ~skip;
`else
  logic unused_bp;
  assign unused_bp = ^{pc_i, bp_addr_i, bp_valid_i};
  assign hit       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RESET;
    end else begin
      state <= state_n;
    end
  end

  // Request priority is halt > step > run; each state only honours its own subset.
  always_comb begin
    state_n = state;
    case (state)
      S_RESET: begin
        if (hold_done) begin
          state_n = START_HALTED ? S_HALT : S_RUN;
        end
      end
      S_RUN: begin
        if (halt_req || hit) begin
          state_n = S_HALT;
        end
      end
      S_HALT: begin
        if (step_req) begin
          state_n = S_STEP;
        end else if (run_req) begin
          state_n = S_RUN;
        end
      end
      S_STEP:  state_n = S_HALT;
      default: state_n = S_RESET;
    endcase
  end

  always_comb begin
    core_rst  = (state == S_RESET);
    core_en   = (state == S_RUN) || (state == S_STEP);
    halted    = (state == S_HALT);
    bp_hit    = hit;
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
    end else if (core_en) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule
